// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared types and constants for the gpr_file register array
package gpr_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } gpr_state_e;

  localparam int GPR_DEF_DATA_W   = 32;
  localparam int GPR_DEF_NUM_REGS = 16;
  localparam int GPR_R0_IDX       = 0;

endpackage

// File: rtl/gpr_sweep_fsm.sv
// rtl/gpr_sweep_fsm.sv - clear-sweep sequencer: walks every register index writing zero
module gpr_sweep_fsm
  import gpr_pkg::*;
#(
  parameter int NUM_REGS = GPR_DEF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sweep_req,
  output logic          sweep_busy,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_idx,
  output logic          wr_allow
);

  gpr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sweep_busy = 1'b0;
    sweep_we   = 1'b0;
    wr_allow   = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep_busy = 1'b1;
        sweep_we   = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == AW'(NUM_REGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        wr_allow = 1'b1;
        if (sweep_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign sweep_idx = cnt_q;

endmodule

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - parametrised register array with registered reads and R0 BAout zeroing
// Optional write-first read bypass selected by macro GPR_BYPASS_EN.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int  DATA_W   = GPR_DEF_DATA_W,
  parameter int  NUM_REGS = GPR_DEF_NUM_REGS,
  parameter int  RD_PORTS = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [RD_PORTS-1:0]        rd_en,
  input  logic [RD_PORTS*AW-1:0]     rd_addr,
  input  logic [RD_PORTS-1:0]        ba_out,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_valid,
  input  logic                       sweep_req,
  output logic                       sweep_busy,
  output logic                       wr_drop
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              sweep_we;
  logic [AW-1:0]     sweep_idx;
  logic              wr_allow;
  logic              wr_fire;

  gpr_sweep_fsm #(
    .NUM_REGS(NUM_REGS),
    .AW      (AW)
  ) u_sweep (
    .clk       (clk),
    .clr       (clr),
    .sweep_req (sweep_req),
    .sweep_busy(sweep_busy),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx),
    .wr_allow  (wr_allow)
  );

  assign wr_fire = wr_en & wr_allow;

  // No reset on the array itself; the sweep provides the cleared state.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en & ~wr_allow;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign addr = rd_addr[p*AW +: AW];

    always_comb begin
      rd_val = mem[addr];
`ifdef GPR_BYPASS_EN
      if (wr_fire && (wr_addr == addr)) begin
        rd_val = wr_data;
      end
`endif
      // BAout zeroing wins over the bypass.
      if (ba_out[p] && (addr == AW'(GPR_R0_IDX))) begin
        rd_val = '0;
      end
    end

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (sweep_busy) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[p];
        if (rd_en[p]) begin
          data_q <= rd_val;
        end
      end
    end

    // Gate with sweep_busy so a read issued in the last IDLE cycle is hidden.
    assign rd_data[p*DATA_W +: DATA_W] = sweep_busy ? '0 : data_q;
    assign rd_valid[p]                 = valid_q & ~sweep_busy;
  end

endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - scoreboard bench for gpr_file (default parameters)
module tb_gpr_file;

  logic        clk;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [1:0]  ba_out;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        sweep_req;
  logic        sweep_busy;
  logic        wr_drop;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  string       nm0[$];
  string       nm1[$];

`ifdef GPR_BYPASS_EN
  localparam logic [31:0] R7_SAME_CYC = 32'h1234_5678;
`else
  localparam logic [31:0] R7_SAME_CYC = 32'h0000_0000;
`endif

  gpr_file dut (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .ba_out    (ba_out),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .sweep_req (sweep_req),
    .sweep_busy(sweep_busy),
    .wr_drop   (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every rd_valid pops the oldest expectation of that port.
  always @(negedge clk) begin
    if (clr) begin
      if (rd_valid[0]) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid0 actual=%h required=no_valid", rd_data[31:0]);
        end else begin
          chk(nm0.pop_front(), {32'h0, rd_data[31:0]}, {32'h0, exp0.pop_front()});
        end
      end
      if (rd_valid[1]) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid1 actual=%h required=no_valid", rd_data[63:32]);
        end else begin
          chk(nm1.pop_front(), {32'h0, rd_data[63:32]}, {32'h0, exp1.pop_front()});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    wr_en     = 1'b0;
    rd_en     = 2'b00;
    ba_out    = 2'b00;
    sweep_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic rd(input int p, input logic [3:0] a, input logic ba,
                    input logic [31:0] exp, input string nm);
    rd_en[p]          = 1'b1;
    rd_addr[p*4 +: 4] = a;
    ba_out[p]         = ba;
    if (p == 0) begin
      exp0.push_back(exp); nm0.push_back(nm);
    end else begin
      exp1.push_back(exp); nm1.push_back(nm);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!sweep_busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!sweep_busy) break;
      @(negedge clk);
    end
    chk("wait_idle_timeout", {63'h0, sweep_busy}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; ba_out = '0; sweep_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, sweep_busy}, 64'h1);
    chk("rst_valid", {62'h0, rd_valid}, 64'h0);
    chk("rst_drop", {63'h0, wr_drop}, 64'h0);
    chk("rst_data", rd_data, 64'h0);

    clr = 1'b1;
    count_busy(n);
    chk("sweep_len_reset", 64'(n), 64'd16);

    for (int i = 0; i < 16; i++) begin
      rd(0, 4'(i), 1'b0, 32'h0, "swept_p0");
      rd(1, 4'(15 - i), 1'b0, 32'h0, "swept_p1");
      step();
    end

    wr(4'd5, 32'hDEAD_BEEF); step();
    rd(0, 4'd5, 1'b0, 32'hDEAD_BEEF, "r5_p0");
    rd(1, 4'd6, 1'b0, 32'h0, "r6_p1");
    step(); step();
    chk("rd_hold_data", {32'h0, rd_data[31:0]}, 64'hDEAD_BEEF);
    chk("rd_hold_valid", {62'h0, rd_valid}, 64'h0);

    wr(4'd7, 32'h1234_5678);
    rd(1, 4'd7, 1'b0, R7_SAME_CYC, "r7_same_cycle");
    step();
    rd(1, 4'd7, 1'b0, 32'h1234_5678, "r7_after");
    step();

    wr(4'd0, 32'h0000_1234); step();
    rd(0, 4'd0, 1'b1, 32'h0, "r0_ba_on");
    rd(1, 4'd0, 1'b0, 32'h0000_1234, "r0_ba_off");
    step();
    wr(4'd0, 32'h0000_5555);
    rd(0, 4'd0, 1'b1, 32'h0, "r0_ba_same_cycle");
    step();
    rd(1, 4'd0, 1'b0, 32'h0000_5555, "r0_new");
    step();

    wr(4'd3, 32'h0F0F_0F0F); step();
    rd(0, 4'd3, 1'b0, 32'h0F0F_0F0F, "r3_before_sweep");
    step(); step();

    // Read in the request cycle and during the sweep must never produce rd_valid.
    sweep_req = 1'b1;
    rd_en[0] = 1'b1; rd_addr[3:0] = 4'd5;
    step();
    chk("req_busy", {63'h0, sweep_busy}, 64'h1);
    chk("req_no_drop", {63'h0, wr_drop}, 64'h0);
    step();
    wr(4'd3, 32'hAAAA_5555);
    rd_en[0] = 1'b1; rd_addr[3:0] = 4'd3;
    step();
    chk("wr_drop_pulse", {63'h0, wr_drop}, 64'h1);
    step();
    chk("wr_drop_single", {63'h0, wr_drop}, 64'h0);
    wait_idle();
    rd(0, 4'd3, 1'b0, 32'h0, "r3_after_sweep");
    rd(1, 4'd5, 1'b0, 32'h0, "r5_after_sweep");
    step();
    rd(0, 4'd7, 1'b0, 32'h0, "r7_after_sweep");
    rd(1, 4'd0, 1'b0, 32'h0, "r0_after_sweep");
    step(); step();

    wr(4'd9, 32'h9999_9999); step();
    sweep_req = 1'b1; step();
    repeat (9) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("midsweep_rst_busy", {63'h0, sweep_busy}, 64'h1);
    chk("midsweep_rst_valid", {62'h0, rd_valid}, 64'h0);
    @(negedge clk);
    clr = 1'b1;
    count_busy(n);
    chk("sweep_len_restart", 64'(n), 64'd16);
    rd(0, 4'd9, 1'b0, 32'h0, "r9_after_restart");
    rd(1, 4'd15, 1'b0, 32'h0, "r15_after_restart");
    step();
    repeat (3) step();

    chk("queue0_drained", 64'(exp0.size()), 64'h0);
    chk("queue1_drained", 64'(exp1.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
# gpr_file

Parametrised general-purpose register file for the Mini SRC datapath family. It replaces the fixed bank of sixteen individually instantiated 32-bit registers with a generic array. The array has configurable width, depth and number of read ports, registered reads, and Mini SRC base-address (BAout) semantics on R0. A built-in sweep engine zeroes the array after reset or on request, so storage needs no per-bit reset and maps onto RAM-style resources.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of registers; power of two, ≥ 2
- RD_PORTS, 2, number of independent read ports, 1..4
- AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe
- wr_addr  in  AW  write register index
- wr_data  in  DATA_W  write data
- rd_en  in  RD_PORTS  per-port read strobe
- rd_addr  in  RD_PORTS*AW  packed read indices, port p at [p*AW +: AW]
- ba_out  in  RD_PORTS  per-port BAout; index 0 reads as zero
- rd_data  out  RD_PORTS*DATA_W  packed registered read data
- rd_valid  out  RD_PORTS  per-port valid, one cycle after rd_en
- sweep_req  in  1  request a full-array clear
- sweep_busy  out  1  sweep in progress
- wr_drop  out  1  one-cycle pulse: a write was discarded

## Operation
- FSM states: SWEEP, IDLE.
- On reset assertion:
  - Enter SWEEP with sweep counter = 0.
  - All outputs go to 0, except sweep_busy = 1.
- SWEEP:
  - Each cycle, write 0 to register[counter] and increment the counter.
  - On the cycle counter = NUM_REGS-1, write that last register and go to IDLE.
  - Duration is exactly NUM_REGS cycles.
- While in SWEEP:
  - wr_en is ignored and wr_drop pulses for each ignored write.
  - rd_valid and rd_data are forced to 0.
  - sweep_req is ignored.
- IDLE:
  - sweep_req = 1 enters SWEEP on the next edge.
  - If wr_en is high in that same cycle, the write is performed first, then zeroed by the sweep.
- Writes in IDLE: wr_data is stored into register[wr_addr] on the edge.
  - R0 is an ordinary writable register.
- Reads in IDLE, per port p with rd_en[p] = 1:
  - The next cycle, rd_valid[p] = 1.
  - rd_data[p] = 0 if ba_out[p] = 1 and rd_addr[p] = 0; otherwise register[rd_addr[p]].
  - With rd_en[p] = 0, rd_data[p] holds its previous value and rd_valid[p] = 0.
- Read ports are independent. Several ports may address the same register.
- Reset mid-sweep restarts the sweep from register 0.

## Timing
- Write latency: 1 edge.
- Read latency: 1 cycle (address sampled at edge N, data valid after edge N).
- sweep_busy:
  - Rises the edge after sweep_req, or asynchronously at reset.
  - Falls the edge after the last sweep write.
  - The first read accepted in IDLE returns data one cycle later.
- Same-cycle write and read to the same index: governed by GPR_BYPASS_EN.
- wr_drop: registered; asserted the cycle after the discarded wr_en.

## Configuration
- GPR_BYPASS_EN:
  - Defined: write-first. A read in the same cycle as a write to the same index returns the new wr_data (ba_out zeroing still takes precedence for index 0).
  - Undefined: read-first. The read returns the value held before the write.

## Structure
- Shared package gpr_pkg:
  - state enum (SWEEP, IDLE)
  - default width/depth constants
  - the R0 index constant for BAout
- Sub-module gpr_sweep_fsm:
  - Holds the state and counter.
  - Outputs sweep_busy, sweep write enable/index, and the write-gating signal.
- The array, read ports and bypass stay in gpr_file.

## Test plan
- Reset release, default params → sweep_busy high exactly 16 cycles. Afterwards, reads of R0..R15 return 0x00000000 with rd_valid.
- Write R5 = 0xDEADBEEF, read R5 on port 0 next cycle → rd_data[0] = 0xDEADBEEF; port 1 reading R6 concurrently → 0.
- Write R7 = 0x12345678 and read R7 on port 1 in the same cycle:
  - with GPR_BYPASS_EN → 0x12345678;
  - without it → prior value 0.
- Write R0 = 0x00001234, then:
  - read port 0 with ba_out[0] = 1 → 0;
  - read port 1 with ba_out[1] = 0 → 0x00001234.
- sweep_req in IDLE, then wr_en to R3 = 0xAAAA5555 two cycles later → wr_drop pulses once; after the sweep, R3 reads 0.
- Assert clr at sweep counter = 9, release → sweep restarts at 0 and sweep_busy stays high for a full 16 more cycles.
